// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller: FSM states,
// default timing parameters, the registered output bundle and block selection.
package sram_ctrl_pkg;

  localparam int DEF_WAIT_STATES = 2;
  localparam int DEF_WAIT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK
  } state_e;

  typedef struct packed {
    logic [3:0] ce_l;
    logic       oe_l;
    logic       we_l;
    logic       ub_l;
    logic       lb_l;
    logic       dtack_l;
  } sram_out_t;

  localparam sram_out_t OUT_INACTIVE = '1;

  // Lowest-index block wins when the decoder presents more than one select.
  function automatic logic [3:0] sel_ce_l(input logic [3:0] blk);
    logic [3:0] ce_l;
    ce_l = '1;
    if (blk[0])      ce_l[0] = 1'b0;
    else if (blk[1]) ce_l[1] = 1'b0;
    else if (blk[2]) ce_l[2] = 1'b0;
    else if (blk[3]) ce_l[3] = 1'b0;
    return ce_l;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: load a value, decrement towards zero, flag zero.
module sram_wait_counter #(
  parameter int WAIT_W = 4
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              zero_o
);

  logic [WAIT_W-1:0] cnt_q;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_controller.sv
// 68000-to-SRAM access sequencer: chip enable / strobe generation for four
// 64 KB blocks with programmable wait states and registered DTACK.
module sram_access_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int WAIT_W      = DEF_WAIT_W
) (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       AS_L,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       RW,
  input  logic [3:0] Block_H,
  output logic [3:0] SRamCE_L,
  output logic       SRamOE_L,
  output logic       SRamWE_L,
  output logic       SRamUB_L,
  output logic       SRamLB_L,
  output logic       Dtack_L
);

  state_e    state_q;
  sram_out_t out_q;
  logic      rw_q;
  logic      arm_q;
  logic      start;
  logic      cnt_zero;

  // A new cycle needs IDLE to have seen AS_L high, so an address strobe held
  // low straight out of ACK can never be acknowledged twice.
  assign start = arm_q && !AS_L && (Block_H != 4'b0000) && (!UDS_L || !LDS_L);

  sram_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_counter (
    .Clock      (Clock),
    .Reset_L    (Reset_L),
    .load_i     (state_q == SETUP),
    .dec_i      (state_q == ACCESS),
    .load_val_i (WAIT_W'(WAIT_STATES)),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      out_q   <= OUT_INACTIVE;
      rw_q    <= 1'b1;
      arm_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (AS_L) begin
            arm_q <= 1'b1;
          end else if (start) begin
            state_q    <= SETUP;
            arm_q      <= 1'b0;
            rw_q       <= RW;
            out_q.ce_l <= sel_ce_l(Block_H);
            out_q.ub_l <= UDS_L;
            out_q.lb_l <= LDS_L;
            out_q.oe_l <= !RW;
          end
        end
        SETUP: begin
          if (AS_L) begin
            state_q <= IDLE;
            out_q   <= OUT_INACTIVE;
          end else begin
            state_q    <= ACCESS;
            out_q.we_l <= rw_q;
          end
        end
        ACCESS: begin
          // Abort takes precedence over completion: no DTACK once AS_L is gone.
          if (AS_L) begin
            state_q <= IDLE;
            out_q   <= OUT_INACTIVE;
          end else if (cnt_zero) begin
            state_q       <= ACK;
            out_q.we_l    <= 1'b1;
            out_q.dtack_l <= 1'b0;
          end
        end
        ACK: begin
          if (AS_L) begin
            state_q <= IDLE;
            out_q   <= OUT_INACTIVE;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= OUT_INACTIVE;
        end
      endcase
    end
  end

  assign SRamCE_L = out_q.ce_l;
  assign SRamOE_L = out_q.oe_l;
  assign SRamWE_L = out_q.we_l;
  assign SRamUB_L = out_q.ub_l;
  assign SRamLB_L = out_q.lb_l;
  assign Dtack_L  = out_q.dtack_l;

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
Downstream stage of the SRAM block decoder. It consumes the four one-hot block selects together with the 68000 bus strobes, and drives the chip enables and control strobes of the four 64 KB SRAM blocks. It inserts a programmable number of wait states and returns DTACK to the CPU. All bus inputs are synchronous to Clock, because the 68000 runs from the same clock.

Parameters:
WAIT_STATES, 2, number of extra cycles spent in ACCESS (range 0..15)
WAIT_W, 4, width of the wait-state counter

Ports:
Clock  in  1  system clock, rising edge active
Reset_L  in  1  asynchronous active-low reset
AS_L  in  1  68k address strobe
UDS_L  in  1  68k upper data strobe
LDS_L  in  1  68k lower data strobe
RW  in  1  68k read/write (1 = read)
Block_H  in  4  block selects from the SRAM block decoder; bit n = Block n
SRamCE_L  out  4  per-block chip enable
SRamOE_L  out  1  output enable (shared across blocks)
SRamWE_L  out  1  write enable (shared across blocks)
SRamUB_L  out  1  upper byte lane enable
SRamLB_L  out  1  lower byte lane enable
Dtack_L  out  1  data acknowledge to the CPU

Behaviour:
- Reset: Reset_L low forces state IDLE and sets all outputs high (inactive) asynchronously. Reset applies mid-cycle as well; no acknowledge is produced.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SETUP, ACCESS, ACK.
- IDLE -> SETUP when AS_L=0, Block_H!=0 and (UDS_L=0 or LDS_L=0). On this edge:
  - latch the selected block, using lowest-index priority if more than one bit is set;
  - latch RW, and latch UB/LB = UDS_L/LDS_L;
  - assert the selected SRamCE_L bit and SRamUB_L/SRamLB_L;
  - assert SRamOE_L if RW=1.
- Write cycles where DS arrives after AS simply remain in IDLE until a DS is low.
- SETUP -> ACCESS unconditionally. Load counter with WAIT_STATES. If the latched RW=0, assert SRamWE_L.
- ACCESS:
  - counter != 0: decrement and stay;
  - counter == 0: go to ACK, deassert SRamWE_L and assert Dtack_L.
  - ACCESS therefore lasts WAIT_STATES+1 cycles. CE, OE, UB and LB stay constant, so data hold after WE is guaranteed.
- ACK: hold CE/OE/UB/LB/Dtack_L until AS_L=1 is sampled. Then return to IDLE with all outputs deasserted on the same edge.
- Latency: AS/DS/select sampled at edge N gives CE low after N, WE low after N+1, and Dtack_L low after edge N+2+WAIT_STATES. With default 2, that is N+4.
- Abort: AS_L=1 sampled in SETUP or ACCESS returns to IDLE with all outputs deasserted, and Dtack_L is never asserted.
- Block_H, RW and DS changes after SETUP entry are ignored because the values are latched.
- Back-to-back cycles: IDLE must sample AS_L=1 at least once before a new cycle starts. This makes AS_L low persisting straight out of ACK impossible to double-acknowledge.
- SRamWE_L and SRamOE_L are never low simultaneously.
- At most one SRamCE_L bit is ever low.

Decomposition:
- Shared package sram_ctrl_pkg:
  - state enumeration (IDLE, SETUP, ACCESS, ACK);
  - default WAIT_STATES constant;
  - WAIT_W;
  - constant for the inactive output vector (all ones).
- One natural sub-module: sram_wait_counter. It provides load/decrement/zero flag, WAIT_W bits wide, with async active-low reset.

Test Plan:
- Read, WAIT_STATES=2: AS_L=0, UDS_L=LDS_L=0, RW=1, Block_H=4'b0100 at edge 0.
  - After edge 0: SRamCE_L=4'b1011, OE_L=0, WE_L=1.
  - Dtack_L=0 after edge 4.
  - All outputs high one edge after AS_L returns to 1.
- Byte write to block 3: RW=0, UDS_L=0, LDS_L=1, Block_H=4'b1000.
  - SRamCE_L=4'b0111, UB_L=0, LB_L=1.
  - WE_L low for exactly 3 cycles (edges 1-4), OE_L=1 throughout.
  - WE_L high on the same edge that Dtack_L goes low.
- Abort: start a read, then drive AS_L=1 during ACCESS.
  - Controller returns to IDLE next edge.
  - Dtack_L never asserts, all CE high.
- Reset mid-write: drop Reset_L during ACCESS.
  - WE_L, CE_L and Dtack_L go high immediately, without waiting for a clock edge.
  - After release, the next valid cycle completes normally.
- WAIT_STATES=0 build plus illegal select Block_H=4'b0110.
  - Block 1 is chosen (SRamCE_L=4'b1101).
  - Dtack_L low after edge 2.
  - Holding AS_L low for 5 extra cycles produces no second cycle.
